// File: rtl/priority_encoder_pending_n.sv
// priority_encoder_pending_n
//   Registered N-input priority encoder with sticky request capture.
//   Request bits are latched into a pending vector. The winning pending index is
//   offered on a valid/ready port, and each accepted index clears its pending bit.
//
//   Build option: define PRIORITY_ENCODER_RR_EN for rotating priority. A pointer
//   then remembers the last accepted index, and the search restarts just below it.
//   With the macro undefined the encoder is fixed priority: the highest index wins,
//   and no pointer register exists.
//
//   Handshake: valid/idx are registered. A transfer completes on a rising edge where
//   valid && ready. While valid && !ready, valid and idx hold steady and are not
//   preempted by newer or higher-priority requests. valid never depends
//   combinationally on ready.
module priority_encoder_pending_n #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         req,
    input  logic                     ready,
    output logic                     valid,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic [WIDTH-1:0]         pend,
    output logic                     any
);

    localparam int IDX_W = $clog2(WIDTH);

    // Pending vector and presented (registered) output.
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Handshake and derived terms.
    logic             acc;
    logic             load;
    logic [WIDTH-1:0] clrmask;
    logic [IDX_W-1:0] win;

`ifdef PRIORITY_ENCODER_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Rotating search: walk downward from ptr-1 (mod WIDTH).
    // A bit's rank is its distance below the start position, wrapping through
    // WIDTH-1. The set bit with the smallest rank wins. Doing this with explicit
    // distances keeps the wrap correct when WIDTH is not a power of two.
    function automatic logic [IDX_W-1:0] enc_rr(input logic [WIDTH-1:0] v,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] r;
        int               start;
        int               dist;
        int               best;
        r     = '0;
        best  = WIDTH;
        start = (p == '0) ? (WIDTH - 1) : (int'(p) - 1);
        for (int i = 0; i < WIDTH; i++) begin
            dist = start - i;
            if (dist < 0) begin
                dist = dist + WIDTH;
            end
            if (v[i] && (dist < best)) begin
                best = dist;
                r    = IDX_W'(i);
            end
        end
        return r;
    endfunction
`else
    // Fixed priority: the highest set index wins. The result is 0 for an empty vector.
    function automatic logic [IDX_W-1:0] enc_fixed(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction
`endif

    // Handshake decode: an accept clears exactly the presented bit.
    always_comb begin
        acc     = valid_q && ready;
        clrmask = '0;
        if (acc) begin
            clrmask = WIDTH'(1) << idx_q;
        end
    end

    // Next pending vector: a request wins over the accept clear, and clr wins over both.
    always_comb begin
        pend_d = (pend_q & ~clrmask) | req;
        if (clr) begin
            pend_d = '0;
        end
    end

`ifdef PRIORITY_ENCODER_RR_EN
    // Pointer follows every accepted index. clr returns it to the fixed-priority start.
    always_comb begin
        ptr_d = ptr_q;
        if (acc) begin
            ptr_d = idx_q;
        end
        if (clr) begin
            ptr_d = '0;
        end
    end

    // Winner is searched against the pointer value that will be live after this edge.
    always_comb begin
        win = enc_rr(pend_d, ptr_d);
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Winner from the next pending vector, so a fresh request is visible immediately.
    always_comb begin
        win = enc_fixed(pend_d);
    end
`endif

    // Output slot reloads only when empty or being drained. Otherwise it holds (no preemption).
    always_comb begin
        load    = !valid_q || acc;
        valid_d = valid_q;
        idx_d   = idx_q;
        if (clr) begin
            valid_d = 1'b0;
            idx_d   = '0;
        end else if (load) begin
            valid_d = |pend_d;
            idx_d   = (|pend_d) ? win : '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign valid = valid_q;
    assign idx   = idx_q;
    assign pend  = pend_q;
    assign any   = |pend_q;

endmodule
